// File: rtl/fwd_scoreboard_multi_pkg.sv
// rtl/fwd_scoreboard_multi_pkg.sv - shared widths and register constants for the ID bypass unit
package fwd_scoreboard_multi_pkg;

  localparam int unsigned FWD_DATA_WIDTH   = 32;
  localparam int unsigned FWD_REG_ADDR_W   = 5;
  localparam int unsigned FWD_NUM_STAGES   = 3;
  localparam int unsigned FWD_NUM_RD_PORTS = 2;
  localparam int unsigned FWD_X0_IDX       = 0;
  localparam int unsigned FWD_CNT_W        = 32;

endpackage

// File: rtl/fwd_scoreboard_multi_port_sel.sv
// rtl/fwd_scoreboard_multi_port_sel.sv - per-read-port youngest-match selection over the slot vectors
module fwd_port_sel
  import fwd_scoreboard_multi_pkg::*;
#(
  parameter int unsigned NUM_STAGES = FWD_NUM_STAGES,
  parameter int unsigned DATA_WIDTH = FWD_DATA_WIDTH,
  parameter int unsigned REG_ADDR_W = FWD_REG_ADDR_W
) (
  input  logic [NUM_STAGES-1:0]                 slot_valid,
  input  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] slot_rd,
  input  logic [NUM_STAGES-1:0]                 slot_ready,
  input  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] slot_data,
  input  logic                                  rs_used,
  input  logic [REG_ADDR_W-1:0]                 rs_addr,
  input  logic [DATA_WIDTH-1:0]                 rs_rf_data,
  output logic [DATA_WIDTH-1:0]                 fwd_data,
  output logic                                  fwd_hit,
  output logic                                  port_stall
);

  logic [NUM_STAGES-1:0] match;

  always_comb begin
    match      = '0;
    fwd_data   = rs_rf_data;
    fwd_hit    = 1'b0;
    port_stall = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      match[i] = slot_valid[i] & rs_used & (slot_rd[i] == rs_addr)
               & (rs_addr != REG_ADDR_W'(FWD_X0_IDX));
    end
    // Walk oldest to youngest so the youngest match is the last one to write.
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (match[i]) begin
        if (slot_ready[i]) begin
          fwd_data   = slot_data[i];
          fwd_hit    = 1'b1;
          port_stall = 1'b0;
        end else begin
          fwd_data   = rs_rf_data;
          fwd_hit    = 1'b0;
          port_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_multi.sv
// rtl/fwd_scoreboard_multi.sv - in-flight write scoreboard with operand bypass and load-use stall
module fwd_scoreboard_multi
  import fwd_scoreboard_multi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = FWD_DATA_WIDTH,
  parameter int unsigned REG_ADDR_W   = FWD_REG_ADDR_W,
  parameter int unsigned NUM_STAGES   = FWD_NUM_STAGES,
  parameter int unsigned NUM_RD_PORTS = FWD_NUM_RD_PORTS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pipe_advance,
  input  logic                               issue_valid,
  input  logic                               issue_we,
  input  logic [REG_ADDR_W-1:0]              issue_rd,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0]   stage_data,
  input  logic [NUM_STAGES-1:0]              stage_data_vld,
  input  logic [NUM_STAGES-1:0]              flush_mask,
  input  logic [NUM_RD_PORTS-1:0]            rs_used,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] rs_addr,
  input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_rf_data,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_fwd_data,
  output logic [NUM_RD_PORTS-1:0]            rs_fwd_hit,
  output logic                               stall,
  output logic [FWD_CNT_W-1:0]               stall_cycles
);

  logic [NUM_STAGES-1:0]                 slot_valid_q, slot_valid_d;
  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] slot_rd_q, slot_rd_d;
  logic [NUM_STAGES-1:0]                 slot_ready_q, slot_ready_d;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] slot_data_q, slot_data_d;
  logic [FWD_CNT_W-1:0]                  stall_cycles_q, stall_cycles_d;

  logic [NUM_STAGES-1:0]                   eff_ready;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0]   eff_data;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] sel_data;
  logic [NUM_RD_PORTS-1:0]                 sel_hit;
  logic [NUM_RD_PORTS-1:0]                 sel_stall;
  logic                                    flush;
  logic                                    issue_ok;

  always_comb begin
    eff_ready = '0;
    eff_data  = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      eff_ready[i] = slot_ready_q[i] | stage_data_vld[i];
      eff_data[i]  = stage_data_vld[i] ? stage_data[i*DATA_WIDTH +: DATA_WIDTH] : slot_data_q[i];
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_port_sel #(
      .NUM_STAGES (NUM_STAGES),
      .DATA_WIDTH (DATA_WIDTH),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_port_sel (
      .slot_valid (slot_valid_q),
      .slot_rd    (slot_rd_q),
      .slot_ready (eff_ready),
      .slot_data  (eff_data),
      .rs_used    (rs_used[p]),
      .rs_addr    (rs_addr[p*REG_ADDR_W +: REG_ADDR_W]),
      .rs_rf_data (rs_rf_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .fwd_data   (sel_data[p]),
      .fwd_hit    (sel_hit[p]),
      .port_stall (sel_stall[p])
    );
  end

  // Outputs fall back to pass-through whenever reset is held, independent of slot state.
  always_comb begin
    rs_fwd_data = rs_rf_data;
    rs_fwd_hit  = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (rst_n) begin
        rs_fwd_data[p*DATA_WIDTH +: DATA_WIDTH] = sel_data[p];
        rs_fwd_hit[p]                           = sel_hit[p];
      end
    end
    stall = rst_n & (|sel_stall);
  end

  assign flush    = |flush_mask;
  assign issue_ok = issue_valid & issue_we & (issue_rd != REG_ADDR_W'(FWD_X0_IDX)) & ~stall & ~flush;

  always_comb begin
    slot_valid_d = '0;
    slot_rd_d    = slot_rd_q;
    slot_ready_d = '0;
    slot_data_d  = eff_data;
    if (pipe_advance) begin
      for (int i = 1; i < NUM_STAGES; i++) begin
        slot_valid_d[i] = slot_valid_q[i-1] & ~flush_mask[i-1];
        slot_rd_d[i]    = slot_rd_q[i-1];
        slot_ready_d[i] = eff_ready[i-1] & ~flush_mask[i-1];
        slot_data_d[i]  = eff_data[i-1];
      end
      slot_valid_d[0] = issue_ok;
      slot_rd_d[0]    = issue_rd;
      slot_ready_d[0] = 1'b0;
      slot_data_d[0]  = '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        slot_valid_d[i] = slot_valid_q[i] & ~flush_mask[i];
        slot_ready_d[i] = eff_ready[i] & ~flush_mask[i];
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {FWD_CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q   <= '0;
      slot_rd_q      <= '0;
      slot_ready_q   <= '0;
      slot_data_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      slot_valid_q   <= slot_valid_d;
      slot_rd_q      <= slot_rd_d;
      slot_ready_q   <= slot_ready_d;
      slot_data_q    <= slot_data_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
